// File: rtl/ch_debounce.sv
// ch_debounce: two-flop synchronizer plus per-bit stability counter for CH7..CH0.
// Ports: CLK, RST (sync, active-high), CH_RAW[7:0], HOLD -> CH_OUT[7:0], CH_CHG[7:0], CH_ANY.
module ch_debounce #(
  parameter int DEB_CYCLES = 50000,
  parameter int CNT_W      = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] CH_RAW,
  input  logic       HOLD,
  output logic [7:0] CH_OUT,
  output logic [7:0] CH_CHG,
  output logic       CH_ANY
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(DEB_CYCLES - 1);

  logic [7:0]       r_s1;
  logic [7:0]       r_s2;
  logic [CNT_W-1:0] r_cnt [8];
  logic [7:0]       r_out;
  logic [7:0]       r_chg;
  logic             r_any;

  logic [CNT_W-1:0] w_cnt_nxt [8];
  logic [7:0]       w_out_nxt;
  logic [7:0]       w_chg_nxt;

  // A bit flips only after S2 has disagreed with CH_OUT for
  // DEB_CYCLES consecutive evaluated edges; any agreement restarts.
  always_comb begin
    w_out_nxt = r_out;
    w_chg_nxt = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (HOLD) begin
        w_cnt_nxt[i] = '0;
      end else if (r_s2[i] == r_out[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == LIM) begin
        w_cnt_nxt[i] = '0;
        w_out_nxt[i] = r_s2[i];
        w_chg_nxt[i] = 1'b1;
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
      end
    end
  end

  // Synchronizers keep sampling during HOLD so a release
  // evaluates already-settled levels.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1  <= 8'h00;
      r_s2  <= 8'h00;
      r_out <= 8'h00;
      r_chg <= 8'h00;
      r_any <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1  <= CH_RAW;
      r_s2  <= r_s1;
      r_out <= w_out_nxt;
      r_chg <= w_chg_nxt;
      r_any <= |w_chg_nxt;
      for (int i = 0; i < 8; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign CH_OUT = r_out;
  assign CH_CHG = r_chg;
  assign CH_ANY = r_any;

endmodule
